// File: rtl/temp_trace_plotter_pkg.sv
// Shared constants, FSM encoding and helper functions for the temperature trace plotter.
package temp_trace_plotter_pkg;

    localparam int N_SAMPLES   = 20;
    localparam int Y_LEVELS    = 300;
    localparam int X_W         = 5;
    localparam int Y_W         = 9;
    localparam int C_W         = 5;
    localparam int HV_W        = 11;
    localparam int COMMIT_LINE = 485;

    typedef enum logic {
        IDLE = 1'b0,
        COPY = 1'b1
    } copy_state_t;

    function automatic logic [Y_W-1:0] clamp_level(input logic [Y_W-1:0] d);
        logic [Y_W-1:0] r;
        if (d >= Y_W'(Y_LEVELS)) begin
            r = Y_W'(Y_LEVELS - 1);
        end else begin
            r = d;
        end
        return r;
    endfunction

    // (wr_ptr - count + k) mod N, kept non-negative by biasing with N first
    function automatic logic [X_W-1:0] ring_index(input logic [X_W-1:0] ptr,
                                                  input logic [C_W-1:0] cnt,
                                                  input logic [X_W-1:0] k);
        logic [5:0] sum;
        sum = 6'(ptr) + 6'(N_SAMPLES) - 6'(cnt) + 6'(k);
        if (sum >= 6'(2 * N_SAMPLES)) begin
            sum = sum - 6'(2 * N_SAMPLES);
        end else if (sum >= 6'(N_SAMPLES)) begin
            sum = sum - 6'(N_SAMPLES);
        end else begin
            sum = sum;
        end
        return sum[X_W-1:0];
    endfunction

endpackage

// File: rtl/temp_trace_plotter_sample_ring_buffer.sv
// Ring of the last N_SAMPLES clamped temperature samples with write pointer,
// saturating fill count, sticky clamp flag and an asynchronous read port.
module sample_ring_buffer
    import temp_trace_plotter_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [Y_W-1:0]   wr_data,
    input  logic [X_W-1:0]   rd_idx,
    output logic [Y_W-1:0]   rd_data,
    output logic [X_W-1:0]   wr_ptr,
    output logic [C_W-1:0]   count,
    output logic             clamp_flag
);

    logic [Y_W-1:0] ring_r [N_SAMPLES];
    logic [X_W-1:0] wr_ptr_r;
    logic [C_W-1:0] count_r;
    logic           clamp_flag_r;

    // Pointer, fill count and sticky clamp flag
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_r     <= {X_W{1'b0}};
            count_r      <= {C_W{1'b0}};
            clamp_flag_r <= 1'b0;
        end else if (wr_en) begin
            wr_ptr_r     <= (wr_ptr_r == X_W'(N_SAMPLES - 1)) ? {X_W{1'b0}} : wr_ptr_r + 5'd1;
            count_r      <= (count_r == C_W'(N_SAMPLES)) ? count_r : count_r + 5'd1;
            clamp_flag_r <= clamp_flag_r | (wr_data >= Y_W'(Y_LEVELS));
        end else begin
            wr_ptr_r     <= wr_ptr_r;
            count_r      <= count_r;
            clamp_flag_r <= clamp_flag_r;
        end
    end

    // Sample storage; contents are only meaningful through the valid bits downstream
    always_ff @(posedge clk) begin
        if (wr_en) begin
            ring_r[wr_ptr_r] <= clamp_level(wr_data);
        end
    end

    assign rd_data    = ring_r[rd_idx];
    assign wr_ptr     = wr_ptr_r;
    assign count      = count_r;
    assign clamp_flag = clamp_flag_r;

endmodule

// File: rtl/temp_trace_plotter.sv
// Temperature trace plotter: sample ring, once-per-frame copy into a tear-free
// display buffer, and a registered per-pixel trace decision.
module temp_trace_plotter
    import temp_trace_plotter_pkg::*;
#(
    parameter int FILL_MODE = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sample_valid,
    input  logic [8:0]       sample_data,
    output logic             sample_ready,
    input  logic [10:0]      hc,
    input  logic [10:0]      vc,
    input  logic             in_grid,
    input  logic [4:0]       matrix_x,
    input  logic [8:0]       matrix_y,
    output logic             pixel_on,
    output logic [4:0]       sample_count,
    output logic             clamp_flag
);

    copy_state_t          state_r, state_nxt_s;
    logic [X_W-1:0]       k_r;
    logic                 rst_done_r;
    logic                 commit_trig_s, copy_en_s, last_k_s, wr_en_s;
    logic [X_W-1:0]       rd_idx_s, wr_ptr_s;
    logic [Y_W-1:0]       rd_data_s;
    logic [C_W-1:0]       count_s;
    logic [Y_W-1:0]       disp_r [N_SAMPLES];
    logic [N_SAMPLES-1:0] disp_valid_r;
    logic                 x_ok_s, y_ok_s, hit_s, pixel_nxt_s, pixel_on_r;
    logic [X_W-1:0]       x_idx_s;
    logic [Y_W-1:0]       level_s;

    assign commit_trig_s = (hc == 11'd0) && (vc == HV_W'(COMMIT_LINE));
    // Ready is held low for the first cycle after reset release as well
    assign sample_ready  = rst_done_r && (state_r == IDLE) && !commit_trig_s;
    assign wr_en_s       = sample_valid && sample_ready;
    assign rd_idx_s      = ring_index(wr_ptr_s, count_s, k_r);

    sample_ring_buffer u_ring (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en      (wr_en_s),
        .wr_data    (sample_data),
        .rd_idx     (rd_idx_s),
        .rd_data    (rd_data_s),
        .wr_ptr     (wr_ptr_s),
        .count      (count_s),
        .clamp_flag (clamp_flag)
    );

    // FSM state register, copy index and post-reset ready gate
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            k_r        <= {X_W{1'b0}};
            rst_done_r <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            k_r        <= (state_r == IDLE) ? {X_W{1'b0}} : k_r + 5'd1;
            rst_done_r <= 1'b1;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE:    state_nxt_s = commit_trig_s ? COPY : IDLE;
            COPY:    state_nxt_s = last_k_s ? IDLE : COPY;
            default: state_nxt_s = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        copy_en_s = (state_r == COPY);
        last_k_s  = copy_en_s && (k_r == X_W'(N_SAMPLES - 1));
    end

    // Display valid bits: cleared by reset so an aborted copy shows nothing
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            disp_valid_r <= {N_SAMPLES{1'b0}};
        end else if (copy_en_s) begin
            disp_valid_r[k_r] <= (C_W'(k_r) < count_s);
        end else begin
            disp_valid_r <= disp_valid_r;
        end
    end

    // Display sample values, oldest at column 0
    always_ff @(posedge clk) begin
        if (copy_en_s) begin
            disp_r[k_r] <= rd_data_s;
        end
    end

    // Pixel hit decision; out-of-range indices are forced dark
    always_comb begin
        x_ok_s  = (matrix_x < X_W'(N_SAMPLES));
        y_ok_s  = (matrix_y < Y_W'(Y_LEVELS));
        x_idx_s = x_ok_s ? matrix_x : {X_W{1'b0}};
        if (y_ok_s) begin
            level_s = Y_W'(Y_LEVELS - 1) - matrix_y;
        end else begin
            level_s = {Y_W{1'b0}};
        end
        if (FILL_MODE == 1) begin
            hit_s = (disp_r[x_idx_s] >= level_s);
        end else begin
            hit_s = (disp_r[x_idx_s] == level_s);
        end
        pixel_nxt_s = in_grid && x_ok_s && y_ok_s && disp_valid_r[x_idx_s] && hit_s;
    end

    // Registered pixel output
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pixel_on_r <= 1'b0;
        end else begin
            pixel_on_r <= pixel_nxt_s;
        end
    end

    assign pixel_on     = pixel_on_r;
    assign sample_count = count_s;

endmodule

// File: tb/tb_temp_trace_plotter.sv
// Directed self-checking bench: line-mode and fill-mode instances share stimulus.
module tb_temp_trace_plotter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sample_valid;
    logic [8:0]  sample_data;
    logic [10:0] hc, vc;
    logic        in_grid;
    logic [4:0]  matrix_x;
    logic [8:0]  matrix_y;
    logic        ready0, ready1, pix0, pix1, clamp0, clamp1;
    logic [4:0]  cnt0, cnt1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [4:0] x;
        logic [8:0] y;
        logic       g;
        logic       e_line;
        logic       e_fill;
    } vec_t;

    vec_t tbl [13];

    always #5 clk = ~clk;

    temp_trace_plotter #(.FILL_MODE(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .sample_valid(sample_valid), .sample_data(sample_data),
        .sample_ready(ready0), .hc(hc), .vc(vc), .in_grid(in_grid), .matrix_x(matrix_x),
        .matrix_y(matrix_y), .pixel_on(pix0), .sample_count(cnt0), .clamp_flag(clamp0)
    );

    temp_trace_plotter #(.FILL_MODE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .sample_valid(sample_valid), .sample_data(sample_data),
        .sample_ready(ready1), .hc(hc), .vc(vc), .in_grid(in_grid), .matrix_x(matrix_x),
        .matrix_y(matrix_y), .pixel_on(pix1), .sample_count(cnt1), .clamp_flag(clamp1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic write(input int v);
        sample_valid = 1'b1;
        sample_data  = 9'(v);
        tick();
        sample_valid = 1'b0;
    endtask

    task automatic commit();
        hc = 11'd0;
        vc = 11'd485;
        tick();
        hc = 11'd1;
        vc = 11'd0;
        repeat (20) tick();
    endtask

    task automatic probe(input string name, input int x, input int y, input logic g,
                         input logic e0, input logic e1);
        matrix_x = 5'(x);
        matrix_y = 9'(y);
        in_grid  = g;
        tick();
        chk({name, "_line"}, int'(pix0), int'(e0));
        chk({name, "_fill"}, int'(pix1), int'(e1));
        in_grid  = 1'b0;
    endtask

    initial begin
        tbl[0]  = '{5'd0,  9'd294, 1'b1, 1'b1, 1'b1};
        tbl[1]  = '{5'd0,  9'd293, 1'b1, 1'b0, 1'b0};
        tbl[2]  = '{5'd0,  9'd299, 1'b1, 1'b0, 1'b1};
        tbl[3]  = '{5'd1,  9'd289, 1'b1, 1'b1, 1'b1};
        tbl[4]  = '{5'd1,  9'd290, 1'b1, 1'b0, 1'b1};
        tbl[5]  = '{5'd2,  9'd0,   1'b1, 1'b1, 1'b1};
        tbl[6]  = '{5'd2,  9'd1,   1'b1, 1'b0, 1'b1};
        tbl[7]  = '{5'd3,  9'd299, 1'b1, 1'b0, 1'b0};
        tbl[8]  = '{5'd19, 9'd0,   1'b1, 1'b0, 1'b0};
        tbl[9]  = '{5'd0,  9'd294, 1'b0, 1'b0, 1'b0};
        tbl[10] = '{5'd0,  9'd300, 1'b1, 1'b0, 1'b0};
        tbl[11] = '{5'd25, 9'd294, 1'b1, 1'b0, 1'b0};
        tbl[12] = '{5'd2,  9'd511, 1'b1, 1'b0, 1'b0};

        rst_n = 1'b0; sample_valid = 1'b0; sample_data = 9'd0;
        hc = 11'd1; vc = 11'd0; in_grid = 1'b0; matrix_x = 5'd0; matrix_y = 9'd0;

        // Reset state
        tick();
        tick();
        chk("rst_ready", int'(ready0), 0);
        chk("rst_pixel", int'(pix0), 0);
        chk("rst_count", int'(cnt0), 0);
        chk("rst_clamp", int'(clamp0), 0);
        rst_n = 1'b1;
        tick();
        chk("rel_ready", int'(ready0), 1);

        // Three samples, table-driven pixel checks
        write(5);
        write(10);
        write(299);
        chk("three_count", int'(cnt0), 3);
        commit();
        for (int i = 0; i < 13; i++) begin
            probe($sformatf("tbl%0d", i), int'(tbl[i].x), int'(tbl[i].y), tbl[i].g,
                  tbl[i].e_line, tbl[i].e_fill);
        end

        // Sample offered in the commit cycle waits out the whole copy
        hc = 11'd0; vc = 11'd485; sample_valid = 1'b1; sample_data = 9'd7;
        #1;
        chk("trig_ready", int'(ready0), 0);
        tick();
        hc = 11'd1; vc = 11'd0;
        for (int c = 2; c <= 21; c++) begin
            chk($sformatf("copy_ready_c%0d", c), int'(ready0), 0);
            tick();
        end
        chk("c22_ready", int'(ready0), 1);
        tick();
        sample_valid = 1'b0;
        chk("c22_count", int'(cnt0), 4);
        commit();
        probe("pending_col3", 3, 292, 1'b1, 1'b1, 1'b1);

        // 25 samples: saturation and oldest-first ordering
        do_reset();
        for (int k = 0; k < 25; k++) write(k);
        chk("sat_count", int'(cnt0), 20);
        commit();
        probe("sat_col0", 0, 294, 1'b1, 1'b1, 1'b1);
        probe("sat_col0_above", 0, 293, 1'b1, 1'b0, 1'b0);
        probe("sat_col19", 19, 275, 1'b1, 1'b1, 1'b1);
        probe("sat_col19_above", 19, 274, 1'b1, 1'b0, 1'b0);
        probe("sat_col10", 10, 284, 1'b1, 1'b1, 1'b1);

        // Clamping and sticky flag
        chk("pre_clamp", int'(clamp0), 0);
        write(400);
        chk("clamp_set", int'(clamp0), 1);
        chk("clamp_count", int'(cnt0), 20);
        commit();
        probe("clamp_col19", 19, 0, 1'b1, 1'b1, 1'b1);
        write(1);
        write(2);
        write(3);
        chk("clamp_sticky", int'(clamp0), 1);
        chk("clamp_sticky_fill", int'(clamp1), 1);

        // Fill mode with a single sample of 100
        do_reset();
        chk("clamp_cleared", int'(clamp0), 0);
        write(100);
        commit();
        probe("fill_top", 0, 199, 1'b1, 1'b1, 1'b1);
        probe("fill_above", 0, 198, 1'b1, 1'b0, 1'b0);
        probe("fill_bottom", 0, 299, 1'b1, 1'b0, 1'b1);
        probe("fill_row0", 0, 0, 1'b1, 1'b0, 1'b0);
        probe("fill_nogrid", 0, 250, 1'b0, 1'b0, 1'b0);
        probe("fill_col1", 1, 299, 1'b1, 1'b0, 1'b0);

        // Reset in the middle of a copy
        write(50);
        hc = 11'd0; vc = 11'd485;
        tick();
        hc = 11'd1; vc = 11'd0;
        repeat (7) tick();
        rst_n = 1'b0;
        #1;
        chk("midcopy_rst_ready", int'(ready0), 0);
        tick();
        tick();
        chk("midcopy_count", int'(cnt0), 0);
        chk("midcopy_pixel", int'(pix1), 0);
        rst_n = 1'b1;
        tick();
        chk("midcopy_rel_ready", int'(ready0), 1);
        probe("midcopy_dark100", 0, 250, 1'b1, 1'b0, 1'b0);
        probe("midcopy_dark_bot", 0, 299, 1'b1, 1'b0, 1'b0);
        commit();
        probe("midcopy_frame", 0, 249, 1'b1, 1'b0, 1'b0);
        probe("midcopy_frame_bot", 0, 299, 1'b1, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
